// File: rtl/life_pkg.sv
// Shared board geometry, power-on seed pattern and sequencer state encoding
// for the Game of Life generation sequencer.
package life_pkg;

    localparam int LIFE_COLS_LOG2 = 3;
    localparam int LIFE_ROWS_LOG2 = 3;
    localparam int LIFE_N         = 1 << (LIFE_COLS_LOG2 + LIFE_ROWS_LOG2);

    // Bits 3,6,8,12,19,22,24,28,35,38,40,42,44,52,53,57,59.
    localparam logic [LIFE_N-1:0] LIFE_SEED_DEFAULT = 64'h0A30_1548_1148_1148;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } life_state_t;

endpackage

// File: rtl/life_cell_rule.sv
// Combinational B3/S23 next-state for one cell of the board; out-of-board
// neighbours are dead unless i_wrap selects toroidal addressing.
module life_cell_rule
#(
    parameter int COLS_LOG2 = 3,
    parameter int ROWS_LOG2 = 3
) (
    input  logic [(1<<(COLS_LOG2+ROWS_LOG2))-1:0] i_board,
    input  logic [COLS_LOG2+ROWS_LOG2-1:0]        i_idx,
    input  logic                                  i_wrap,
    output logic                                  o_next
);

    localparam int RW = ROWS_LOG2 + 1;
    localparam int CW = COLS_LOG2 + 1;

    logic [RW-1:0] w_nr;
    logic [CW-1:0] w_nc;
    logic          w_in_board;
    logic [3:0]    w_cnt;

    // One spare MSB on row/col flags a step off the edge; the low bits are the wrapped coordinate.
    always_comb begin
        w_cnt      = '0;
        w_nr       = '0;
        w_nc       = '0;
        w_in_board = 1'b0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                if (dr != 1 || dc != 1) begin
                    w_nr = {1'b0, i_idx[COLS_LOG2 +: ROWS_LOG2]} + RW'(dr) - RW'(1);
                    w_nc = {1'b0, i_idx[0 +: COLS_LOG2]} + CW'(dc) - CW'(1);
                    w_in_board = !w_nr[ROWS_LOG2] && !w_nc[COLS_LOG2];
                    if ((i_wrap || w_in_board) &&
                        i_board[{w_nr[ROWS_LOG2-1:0], w_nc[COLS_LOG2-1:0]}])
                        w_cnt = w_cnt + 4'd1;
                end
            end
        end
        o_next = (w_cnt == 4'd3) || (i_board[i_idx] && (w_cnt == 4'd2));
    end

endmodule

// File: rtl/life_gen_sequencer.sv
// Game of Life sequencer: one cell per cycle into a shadow board, committed after N cycles.
// Generation = N+1 cycles after trigger; triggers while busy are dropped and flagged in overrun.
// Build option: LIFE_WRAP_EN selects toroidal neighbour addressing (default: dead borders).
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int FRAME_DIV = 60,
    parameter int COLS_LOG2 = LIFE_COLS_LOG2,
    parameter int ROWS_LOG2 = LIFE_ROWS_LOG2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  frame_tick,
    input  logic                                  run,
    input  logic                                  step,
    input  logic                                  seed_load,
    input  logic [(1<<(COLS_LOG2+ROWS_LOG2))-1:0] seed_data,
    output logic [(1<<(COLS_LOG2+ROWS_LOG2))-1:0] board,
    output logic                                  busy,
    output logic                                  gen_done,
    output logic [15:0]                           gen_count,
    output logic                                  overrun
);

    localparam int IW = COLS_LOG2 + ROWS_LOG2;
    localparam int N  = 1 << IW;
    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

`ifdef LIFE_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    life_state_t r_state;
    life_state_t w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [N-1:0]  r_next;
    logic [N-1:0]  r_board;
    logic [FW-1:0] r_fcnt;
    logic [15:0]   r_gen_count;
    logic          r_overrun;
    logic          w_fcnt_last;
    logic          w_trig;
    logic          w_cell_nxt;

    assign w_fcnt_last = (r_fcnt == FW'(FRAME_DIV - 1));
    assign w_trig      = (frame_tick && run && w_fcnt_last) || step;

    life_cell_rule #(
        .COLS_LOG2 (COLS_LOG2),
        .ROWS_LOG2 (ROWS_LOG2)
    ) u_rule (
        .i_board (r_board),
        .i_idx   (r_idx),
        .i_wrap  (WRAP),
        .o_next  (w_cell_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        gen_done    = 1'b0;
        case (r_state)
            IDLE:   if (w_trig) w_state_nxt = EVAL;
            EVAL: begin
                busy = 1'b1;
                if (r_idx == IW'(N - 1)) w_state_nxt = COMMIT;
            end
            COMMIT: begin
                busy        = 1'b1;
                gen_done    = !seed_load;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (seed_load) w_state_nxt = IDLE;
    end

    // The frame divider keeps counting even when the trigger it produces is dropped or overridden.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_next      <= '0;
            r_board     <= N'(LIFE_SEED_DEFAULT);
            r_fcnt      <= '0;
            r_gen_count <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (frame_tick && run)
                r_fcnt <= w_fcnt_last ? '0 : r_fcnt + FW'(1);
            if (seed_load) begin
                r_board     <= seed_data;
                r_gen_count <= '0;
            end else begin
                if (r_state != IDLE && w_trig) r_overrun <= 1'b1;
                case (r_state)
                    IDLE:   if (w_trig) r_idx <= '0;
                    EVAL: begin
                        r_next[r_idx] <= w_cell_nxt;
                        r_idx         <= r_idx + IW'(1);
                    end
                    COMMIT: begin
                        r_board     <= r_next;
                        r_gen_count <= r_gen_count + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign board     = r_board;
    assign gen_count = r_gen_count;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer at default geometry, with a Life reference model
// built from row/column arithmetic on an 8x8 board.
module tb_life_gen_sequencer;

`ifdef LIFE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, frame_tick, run, step, seed_load;
    logic [63:0] seed_data;
    logic [63:0] board;
    logic        busy, gen_done, overrun;
    logic [15:0] gen_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    life_gen_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .run        (run),
        .step       (step),
        .seed_load  (seed_load),
        .seed_data  (seed_data),
        .board      (board),
        .busy       (busy),
        .gen_done   (gen_done),
        .gen_count  (gen_count),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bits2v(input int q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v[q[i]] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] life_step(input logic [63:0] b, input bit wrap);
        logic [63:0] nb = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
                            continue;
                        end
                        n += int'(b[rr*8 + cc]);
                    end
                end
                nb[r*8 + c] = (n == 3) || (b[r*8 + c] && n == 2);
            end
        end
        return nb;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [63:0] v);
        seed_data = v;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic gen_once();
        bit seen = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (gen_done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("gen_done_seen", 64'(seen), 64'd1);
        tick();
    endtask

    initial begin
        int q[$];
        logic [63:0] s, b2, exp;
        int bad, pulses, n;
        int ptick[$];

        reset = 1'b1; frame_tick = 1'b0; run = 1'b0; step = 1'b0;
        seed_load = 1'b0; seed_data = '0;
        repeat (3) tick();
        // reset wins over a simultaneous seed_load and step
        seed_load = 1'b1; seed_data = '1; step = 1'b1;
        tick();
        reset = 1'b0; seed_load = 1'b0; step = 1'b0;
        q = '{3, 6, 8, 12, 19, 22, 24, 28, 35, 38, 40, 42, 44, 52, 53, 57, 59};
        chk("rst_board", board, bits2v(q));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gen_done", 64'(gen_done), 64'd0);
        chk("rst_gen_count", 64'(gen_count), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);

        // Blinker with exact cycle accounting from the step pulse at cycle T.
        q = '{27, 28, 29};
        s = bits2v(q);
        load_seed(s);
        step = 1'b1;
        tick();
        step = 1'b0;
        bad = 0;
        for (int k = 1; k <= 65; k++) begin
            if (busy !== 1'b1) bad++;
            if (gen_done !== (k == 65)) bad++;
            if (board !== s) bad++;
            tick();
        end
        chk("blinker_window", 64'(bad), 64'd0);
        q = '{20, 28, 36};
        chk("blinker_board", board, bits2v(q));
        chk("blinker_model", board, life_step(s, WRAP));
        chk("blinker_busy_after", 64'(busy), 64'd0);
        chk("blinker_count", 64'(gen_count), 64'd1);

        q = '{27, 28, 35, 36};
        s = bits2v(q);
        load_seed(s);
        repeat (3) gen_once();
        chk("block_board", board, s);
        chk("block_count", 64'(gen_count), 64'd3);

        q = '{30, 31, 24};
        load_seed(bits2v(q));
        gen_once();
        q = '{23, 31, 39};
        chk("edge_blinker", board, WRAP ? bits2v(q) : 64'd0);

        for (int r = 0; r < 6; r++) begin
            s = {$urandom, $urandom};
            n = 1 + int'($urandom % 2);
            load_seed(s);
            exp = s;
            for (int g = 0; g < n; g++) begin
                gen_once();
                exp = life_step(exp, WRAP);
            end
            chk("rand_board", board, exp);
            chk("rand_count", 64'(gen_count), 64'(n));
        end

        // Frame divider: one auto generation per 60 accepted ticks.
        q = '{27, 28, 29};
        s = bits2v(q);
        load_seed(s);
        run = 1'b1;
        pulses = 0;
        for (int t = 1; t <= 120; t++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            for (int c = 0; c < 99; c++) begin
                if (gen_done) begin
                    pulses++;
                    ptick.push_back(t);
                end
                tick();
            end
        end
        chk("frame_pulses", 64'(pulses), 64'd2);
        chk("frame_first", 64'(ptick.size() > 0 ? ptick[0] : -1), 64'd60);
        chk("frame_second", 64'(ptick.size() > 1 ? ptick[1] : -1), 64'd120);
        chk("frame_board", board, s);
        chk("frame_count", 64'(gen_count), 64'd2);
        run = 1'b0;
        pulses = 0;
        for (int t = 1; t <= 120; t++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            for (int c = 0; c < 99; c++) begin
                if (gen_done) pulses++;
                tick();
            end
        end
        chk("frame_norun_pulses", 64'(pulses), 64'd0);
        chk("frame_no_overrun", 64'(overrun), 64'd0);

        // seed_load at EVAL idx=30 aborts the scan.
        s = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        load_seed(s);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (30) tick();
        chk("abort_busy_before", 64'(busy), 64'd1);
        seed_data = b2;
        seed_load = 1'b1;
        step = 1'b1;
        tick();
        seed_load = 1'b0;
        step = 1'b0;
        chk("abort_board", board, b2);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_count", 64'(gen_count), 64'd0);
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            if (gen_done !== 1'b0 || board !== b2) bad++;
            tick();
        end
        chk("abort_quiet", 64'(bad), 64'd0);

        // A second step while busy is dropped and flagged.
        s = {$urandom, $urandom};
        load_seed(s);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (5) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("overrun_set", 64'(overrun), 64'd1);
        pulses = 0;
        for (int c = 0; c < 150; c++) begin
            if (gen_done) pulses++;
            tick();
        end
        chk("overrun_pulses", 64'(pulses), 64'd1);
        chk("overrun_board", board, life_step(s, WRAP));
        chk("overrun_count", 64'(gen_count), 64'd1);

        // Reset during EVAL.
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q = '{3, 6, 8, 12, 19, 22, 24, 28, 35, 38, 40, 42, 44, 52, 53, 57, 59};
        chk("midrst_board", board, bits2v(q));
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_overrun", 64'(overrun), 64'd0);
        chk("midrst_count", 64'(gen_count), 64'd0);
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            if (gen_done !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        chk("midrst_quiet", 64'(bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_gen_sequencer.md
LIFE_GEN_SEQUENCER -- requirements
Module: life_gen_sequencer

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 60: the number of accepted frame ticks between automatic generations.
REQ-002 SHALL have parameter COLS_LOG2, default 3: board width is 2**COLS_LOG2 cells.
REQ-003 SHALL have parameter ROWS_LOG2, default 3: board height is 2**ROWS_LOG2 cells. N = cell count (64 at defaults).
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port frame_tick, input, 1 bit: one-cycle pulse at vblank start.
REQ-008 SHALL have port run, input, 1 bit: level; enables automatic generations.
REQ-009 SHALL have port step, input, 1 bit: one-cycle pulse; requests a single generation.
REQ-010 SHALL have port seed_load, input, 1 bit: one-cycle pulse; loads seed_data.
REQ-011 SHALL have port seed_data, input, N bits: the seed pattern.
REQ-012 SHALL have port board, output, N bits: the displayed board, bit index = row*COLS + col.
REQ-013 SHALL have port busy, output, 1 bit: high in states EVAL and COMMIT.
REQ-014 SHALL have port gen_done, output, 1 bit: high for exactly the COMMIT cycle.
REQ-015 SHALL have port gen_count, output, 16 bits: generations committed; wraps.
REQ-016 SHALL have port overrun, output, 1 bit: sticky flag; a trigger was dropped while busy.

Function
REQ-017 SHALL implement FSM states IDLE, EVAL and COMMIT.
REQ-018 Frame counter SHALL increment on frame_tick when run=1, wrap at FRAME_DIV-1, and hold its value when run=0.
REQ-019 An auto trigger SHALL occur on a frame_tick with run=1 and counter=FRAME_DIV-1.
REQ-020 A step trigger SHALL occur on step=1 in any state; it SHALL act regardless of run.
REQ-021 A trigger in IDLE at cycle T SHALL enter EVAL at T+1 with idx=0.
REQ-022 EVAL SHALL process one cell per cycle: count the 8 neighbours of idx from board, apply the B3/S23 rule, and write the result to next[idx].
REQ-023 EVAL SHALL never modify board during the scan.
REQ-024 EVAL SHALL go to COMMIT after idx=N-1. COMMIT occurs at T+N+1 (T+65 at defaults).
REQ-025 In COMMIT: board <= next, gen_count += 1, gen_done=1, then return to IDLE.
REQ-026 A trigger while busy SHALL be dropped and SHALL set overrun; the frame counter SHALL still advance.
REQ-027 Simultaneous auto and step triggers in IDLE SHALL start exactly one generation.
REQ-028 seed_load SHALL take priority over everything:
  - board <= seed_data, gen_count <= 0, FSM -> IDLE.
  - An in-progress scan is aborted; next is discarded and gen_done is not asserted.
  - A trigger in the same cycle is ignored.
REQ-029 Edge cells with wrap disabled SHALL treat out-of-board neighbours as dead.
REQ-030 The neighbour count SHALL be 4 bits wide; the maximum value 8 SHALL NOT overflow.

Reset
REQ-031 reset SHALL set board to the package constant LIFE_SEED_DEFAULT: bits 3,6,8,12,19,22,24,28,35,38,40,42,44,52,53,57,59 set.
REQ-032 reset SHALL clear state to IDLE and clear idx, next, frame counter, gen_count and overrun; busy=0 and gen_done=0.
REQ-033 reset SHALL override seed_load and all triggers, and SHALL abort a scan mid-operation.

Configuration
REQ-034 With macro LIFE_WRAP_EN defined, neighbour addressing SHALL wrap toroidally: row and column modulo board size.
REQ-035 Without LIFE_WRAP_EN, edges SHALL be dead borders per REQ-029.

Structure
REQ-036 Package life_pkg SHALL hold LIFE_SEED_DEFAULT, the state enum typedef (IDLE/EVAL/COMMIT) and the board-size localparams.
REQ-037 Sub-module life_cell_rule SHALL be combinational: inputs board, idx and wrap mode; output next-state bit; SHALL be instantiated once.

Verification
REQ-038 Blinker: seed bits 27,28,29; step pulse at T -> busy T+1..T+65, gen_done only at T+65; board = bits 20,28,36 from T+66; gen_count=1.
REQ-039 Still life block: seed bits 27,28,35,36; 3 steps -> board unchanged; gen_count=3.
REQ-040 Edge blinker: seed bits 30,31,24.
  - LIFE_WRAP_EN defined: one step -> bits 23,31,39.
  - LIFE_WRAP_EN undefined: one step -> board all zero.
REQ-041 Frame divider: run=1, 120 frame_ticks spaced 100 cycles apart -> exactly 2 gen_done pulses, after the 60th and 120th ticks; run=0 -> none.
REQ-042 Abort and overrun:
  - seed_load at EVAL idx=30 -> board = seed_data next cycle, no gen_done, gen_count=0.
  - step while busy -> overrun=1 and the generation is not restarted.
REQ-043 Reset mid-EVAL -> next cycle board = LIFE_SEED_DEFAULT, busy=0, overrun=0.
